// File: rtl/axis_frame_len_arb_if.sv
// Result stream between the frame-length arbiter and its consumer.
//
// Handshake: the master raises tvalid with tdata/tid and holds all three
// stable until it samples tready high on a rising clock edge; a beat
// transfers on every rising edge where tvalid && tready. tready may be
// raised or lowered at any time and never depends on tvalid combinationally
// on the master side.
//
// Signals:
//   tdata   frame length of the granted result
//   tid     index of the monitor port that produced the result
//   tvalid  master has a beat on the bus
//   tready  slave accepts the beat
interface axis_frame_len_arb_if #(
    parameter int LEN_WIDTH = 16,
    parameter int ID_WIDTH  = 2
);
    logic [LEN_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]  tid;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tid, output tvalid, input tready);
    modport slave  (input tdata, input tid, input tvalid, output tready);
endinterface

// File: rtl/axis_frame_len_arb.sv
// axis_frame_len_arb
//
// Collects one-cycle frame-length results from PORTS independent monitors
// and serialises them onto one valid/ready result stream. Each port has a
// one-entry holding register; a round-robin arbiter moves one held result
// per cycle into a single output slot. A strobe that arrives while its
// holding register is still occupied (and not being drained that cycle) is
// dropped and reported on overflow one cycle later.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   in_frame_len        packed lengths, port p at [p*LEN_WIDTH +: LEN_WIDTH]
//   in_frame_len_valid  one-cycle result strobe per port (no backpressure)
//   m_axis              result stream (master modport): tdata, tid, tvalid, tready
//   overflow            one-cycle pulse per port when a result is dropped
//   busy                any holding register or the output slot occupied
//   drop_cnt            per-port saturating drop counters (optional)
//   drop_cnt_clr        synchronous clear of all drop counters (optional)
//
// Optional feature: define FRAME_LEN_ARB_DROP_CNT_EN to add the drop_cnt
// output and drop_cnt_clr input. Without it the counters and both ports are
// absent; overflow behaves identically either way.
module axis_frame_len_arb #(
    parameter int PORTS          = 4,
    parameter int LEN_WIDTH      = 16,
    parameter int ID_WIDTH       = $clog2(PORTS),
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS*LEN_WIDTH-1:0] in_frame_len,
    input  logic [PORTS-1:0]           in_frame_len_valid,
    axis_frame_len_arb_if.master       m_axis,
    output logic [PORTS-1:0]           overflow,
`ifdef FRAME_LEN_ARB_DROP_CNT_EN
    output logic [PORTS*DROP_CNT_WIDTH-1:0] drop_cnt,
    input  logic                            drop_cnt_clr,
`endif
    output logic                       busy
);

    if (PORTS < 2 || PORTS > 16 || DROP_CNT_WIDTH < 1) begin : g_bad_param
        $error("axis_frame_len_arb: illegal parameterisation");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e          state_q;
    slot_state_e          state_d;

    logic [PORTS-1:0]     hold_valid;
    logic [LEN_WIDTH-1:0] hold_len [PORTS];

    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [LEN_WIDTH-1:0] out_data;
    logic [ID_WIDTH-1:0]  out_id;

    logic                 load_en;
    logic                 grant_found;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic [PORTS-1:0]     grant_vec;
    logic [PORTS-1:0]     drop_vec;

    // The slot can take a new beat when it is empty or its current beat is
    // leaving on this edge.
    assign load_en = (state_q == EMPTY) || (m_axis.tready && (state_q == FULL));

    // Round-robin search starting just after the last granted port. The
    // index is reduced by subtraction rather than masking so PORTS need not
    // be a power of two.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            if (!grant_found && hold_valid[ID_WIDTH'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        drop_vec  = '0;
        for (int p = 0; p < PORTS; p++) begin
            grant_vec[p] = load_en && grant_found && (grant_idx == ID_WIDTH'(p));
            // A register being drained this cycle can accept the new strobe.
            drop_vec[p]  = in_frame_len_valid[p] && hold_valid[p] && !grant_vec[p];
        end
    end

    // Output slot FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = grant_found ? FULL : EMPTY;
        end
    end

    // Per-port holding registers and overflow pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= '0;
            overflow   <= '0;
            for (int p = 0; p < PORTS; p++) begin
                hold_len[p] <= '0;
            end
        end else begin
            overflow <= drop_vec;
            for (int p = 0; p < PORTS; p++) begin
                if (in_frame_len_valid[p] && (!hold_valid[p] || grant_vec[p])) begin
                    hold_valid[p] <= 1'b1;
                    hold_len[p]   <= in_frame_len[p*LEN_WIDTH +: LEN_WIDTH];
                end else if (grant_vec[p]) begin
                    hold_valid[p] <= 1'b0;
                end
            end
        end
    end

    // Output data, id and arbitration pointer. Only a grant moves them, so
    // a stalled beat stays stable and idle cycles leave the pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_id   <= '0;
            rr_ptr   <= ID_WIDTH'(PORTS - 1);
        end else if (load_en && grant_found) begin
            out_data <= hold_len[grant_idx];
            out_id   <= grant_idx;
            rr_ptr   <= grant_idx;
        end
    end

    assign m_axis.tdata  = out_data;
    assign m_axis.tid    = out_id;
    assign m_axis.tvalid = (state_q == FULL);

    assign busy = (|hold_valid) || (state_q == FULL);

`ifdef FRAME_LEN_ARB_DROP_CNT_EN
    for (genvar p = 0; p < PORTS; p++) begin : g_drop_cnt
        logic [DROP_CNT_WIDTH-1:0] cnt_q;

        // Clear has priority; the counter holds at all-ones instead of wrapping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (drop_cnt_clr) begin
                cnt_q <= '0;
            end else if (drop_vec[p] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + DROP_CNT_WIDTH'(1);
            end
        end

        assign drop_cnt[p*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_axis_frame_len_arb.sv
// Directed testbench for axis_frame_len_arb (PORTS=4, LEN_WIDTH=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check reflects the registered state of that cycle.
module tb_axis_frame_len_arb;
    localparam int PORTS = 4;
    localparam int LW    = 16;
    localparam int IW    = 2;
    localparam int DW    = 16;

    logic              clk;
    logic              rst_n;
    logic [PORTS*LW-1:0] in_frame_len;
    logic [PORTS-1:0]  in_frame_len_valid;
    logic [PORTS-1:0]  overflow;
    logic              busy;
`ifdef FRAME_LEN_ARB_DROP_CNT_EN
    logic [PORTS*DW-1:0] drop_cnt;
    logic              drop_cnt_clr;
`endif

    int vectors;
    int miscompares;

    axis_frame_len_arb_if #(.LEN_WIDTH(LW), .ID_WIDTH(IW)) m_axis ();

    axis_frame_len_arb #(
        .PORTS(PORTS), .LEN_WIDTH(LW), .ID_WIDTH(IW), .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_frame_len       (in_frame_len),
        .in_frame_len_valid (in_frame_len_valid),
        .m_axis             (m_axis.master),
        .overflow           (overflow),
`ifdef FRAME_LEN_ARB_DROP_CNT_EN
        .drop_cnt           (drop_cnt),
        .drop_cnt_clr       (drop_cnt_clr),
`endif
        .busy               (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        in_frame_len       = '0;
        in_frame_len_valid = '0;
        m_axis.tready      = 1'b1;
`ifdef FRAME_LEN_ARB_DROP_CNT_EN
        drop_cnt_clr       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Driver
    task automatic strobe(input int p, input logic [LW-1:0] len);
        in_frame_len[p*LW +: LW] = len;
        in_frame_len_valid[p]    = 1'b1;
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow, busy} !== {1'b1 ^ 1'b1, 2'd0, 16'd0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got v=%0b id=%0d d=%0d ovf=%b busy=%0b, want all 0",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        repeat (10) step();
        strobe(2, 16'd64);
        step();
        in_frame_len_valid = '0;
        vectors++;
        if ({m_axis.tvalid, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_n1: got tvalid=%0b busy=%0b, want 0 1", m_axis.tvalid, busy);
        end
        step();
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata} !== {1'b1, 2'd2, 16'd64}) begin
            miscompares++;
            $display("FAIL single_n2: got v=%0b id=%0d d=%0d, want 1 2 64",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata);
        end
        step();
        vectors++;
        if ({m_axis.tvalid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_n3: got tvalid=%0b busy=%0b, want 0 0", m_axis.tvalid, busy);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int p = 0; p < PORTS; p++) strobe(p, LW'(60 + p));
        step();
        in_frame_len_valid = '0;
        step();
        for (int b = 0; b < PORTS; b++) begin
            vectors++;
            if ({m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow} !== {1'b1, IW'(b), LW'(60 + b), 4'd0}) begin
                miscompares++;
                $display("FAIL simult_beat%0d: got v=%0b id=%0d d=%0d ovf=%b, want 1 %0d %0d 0000",
                         b, m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow, b, 60 + b);
            end
            step();
        end
        vectors++;
        if ({m_axis.tvalid, busy, overflow} !== 6'd0) begin
            miscompares++;
            $display("FAIL simult_drain: got v=%0b busy=%0b ovf=%b, want 0 0 0000",
                     m_axis.tvalid, busy, overflow);
        end
    endtask

    task automatic test_fairness();
        logic [IW-1:0] exp_id;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            in_frame_len_valid = '0;
            if (k < 20) begin
                strobe(0, LW'(k));
                strobe(3, LW'(100 + k));
            end
            if (k >= 2) begin
                exp_id = (k % 2 == 0) ? 2'd0 : 2'd3;
                vectors++;
                if ({m_axis.tvalid, m_axis.tid} !== {1'b1, exp_id}) begin
                    miscompares++;
                    $display("FAIL fairness_c%0d: got v=%0b id=%0d, want 1 %0d",
                             k, m_axis.tvalid, m_axis.tid, exp_id);
                end
            end
            step();
        end
        in_frame_len_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        m_axis.tready = 1'b0;
        strobe(1, 16'd100);
        step();
        strobe(1, 16'd200);
        step();
        strobe(1, 16'd300);
        step();
        in_frame_len_valid = '0;
        vectors++;
        if ({m_axis.tvalid, m_axis.tdata, overflow, busy} !== {1'b1, 16'd100, 4'b0010, 1'b1}) begin
            miscompares++;
            $display("FAIL bp_stall: got v=%0b d=%0d ovf=%b busy=%0b, want 1 100 0010 1",
                     m_axis.tvalid, m_axis.tdata, overflow, busy);
        end
        step();
        vectors++;
        if ({m_axis.tvalid, m_axis.tdata, overflow} !== {1'b1, 16'd100, 4'b0000}) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%0b d=%0d ovf=%b, want 1 100 0000",
                     m_axis.tvalid, m_axis.tdata, overflow);
        end
        m_axis.tready = 1'b1;
        step();
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata} !== {1'b1, 2'd1, 16'd200}) begin
            miscompares++;
            $display("FAIL bp_second: got v=%0b id=%0d d=%0d, want 1 1 200",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata);
        end
        step();
        vectors++;
        if ({m_axis.tvalid, busy, overflow} !== 6'd0) begin
            miscompares++;
            $display("FAIL bp_drain: got v=%0b busy=%0b ovf=%b, want 0 0 0000",
                     m_axis.tvalid, busy, overflow);
        end
`ifdef FRAME_LEN_ARB_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== {16'd0, 16'd0, 16'd1, 16'd0}) begin
            miscompares++;
            $display("FAIL drop_cnt: got %h, want 0000000000010000", drop_cnt);
        end
        drop_cnt_clr = 1'b1;
        step();
        drop_cnt_clr = 1'b0;
        vectors++;
        if (drop_cnt !== 64'd0) begin
            miscompares++;
            $display("FAIL drop_cnt_clr: got %h, want 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_collision();
        do_reset();
        m_axis.tready = 1'b0;
        strobe(0, 16'd10);
        step();
        strobe(0, 16'd20);
        step();
        in_frame_len_valid = '0;
        vectors++;
        if ({m_axis.tvalid, m_axis.tdata, overflow} !== {1'b1, 16'd10, 4'b0000}) begin
            miscompares++;
            $display("FAIL coll_first: got v=%0b d=%0d ovf=%b, want 1 10 0000",
                     m_axis.tvalid, m_axis.tdata, overflow);
        end
        step();
        m_axis.tready = 1'b1;
        strobe(0, 16'd77);
        step();
        in_frame_len_valid = '0;
        vectors++;
        if ({m_axis.tvalid, m_axis.tdata, overflow} !== {1'b1, 16'd20, 4'b0000}) begin
            miscompares++;
            $display("FAIL coll_grant: got v=%0b d=%0d ovf=%b, want 1 20 0000",
                     m_axis.tvalid, m_axis.tdata, overflow);
        end
        step();
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow} !== {1'b1, 2'd0, 16'd77, 4'b0000}) begin
            miscompares++;
            $display("FAIL coll_new: got v=%0b id=%0d d=%0d ovf=%b, want 1 0 77 0000",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow);
        end
        step();
        vectors++;
        if ({m_axis.tvalid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL coll_drain: got v=%0b busy=%0b, want 0 0", m_axis.tvalid, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_axis.tready = 1'b0;
        strobe(0, 16'd1);
        strobe(1, 16'd2);
        strobe(2, 16'd3);
        step();
        in_frame_len_valid = '0;
        step();
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata, busy} !== {1'b1, 2'd0, 16'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL rmid_pre: got v=%0b id=%0d d=%0d busy=%0b, want 1 0 1 1",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow, busy} !== 24'd0) begin
            miscompares++;
            $display("FAIL rmid_async: got v=%0b id=%0d d=%0d ovf=%b busy=%0b, want all 0",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata, overflow, busy);
        end
        step();
        rst_n         = 1'b1;
        m_axis.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({m_axis.tvalid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL rmid_stale%0d: got v=%0b busy=%0b, want 0 0", k, m_axis.tvalid, busy);
            end
            step();
        end
        strobe(0, 16'd5);
        strobe(1, 16'd6);
        step();
        in_frame_len_valid = '0;
        step();
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata} !== {1'b1, 2'd0, 16'd5}) begin
            miscompares++;
            $display("FAIL rmid_first: got v=%0b id=%0d d=%0d, want 1 0 5",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata);
        end
        step();
        vectors++;
        if ({m_axis.tvalid, m_axis.tid, m_axis.tdata} !== {1'b1, 2'd1, 16'd6}) begin
            miscompares++;
            $display("FAIL rmid_second: got v=%0b id=%0d d=%0d, want 1 1 6",
                     m_axis.tvalid, m_axis.tid, m_axis.tdata);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
